// File: rtl/uart_txq_pkg.sv
// Shared types and defaults for the UART transmit byte queue.
// Optional done-wait watchdog is enabled with UART_TXQ_TIMEOUT_EN.
package uart_txq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } txq_state_t;

  localparam int TXQ_DEPTH   = 16;
  localparam int TXQ_DATA_W  = 8;
  localparam int TXQ_GAP     = 4;
  localparam int TXQ_TIMEOUT = 2000000;

  // Counter width that still holds n-1, never narrower than one bit.
  function automatic int txq_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_queue_fifo.sv
// Synchronous FIFO for the transmit queue: storage, wrapping pointers,
// occupancy count, full/empty flags and a push-while-full strobe.
module txq_fifo
  import uart_txq_pkg::*;
#(
  parameter int DEPTH      = TXQ_DEPTH,
  parameter int DATA_WIDTH = TXQ_DATA_W,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic                  ovf_stb
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // full is taken before any same-cycle pop, so a push at full is dropped
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign ovf_stb = wr_en && full;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue with send/done handshake toward the UART.
// Define UART_TXQ_TIMEOUT_EN to add the done-wait watchdog and timeout flag.
module uart_tx_queue
  import uart_txq_pkg::*;
#(
  parameter int DEPTH          = TXQ_DEPTH,
  parameter int DATA_WIDTH     = TXQ_DATA_W,
  parameter int GAP_CYCLES     = TXQ_GAP
`ifdef UART_TXQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TXQ_TIMEOUT
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      send_tx,
  output logic [DATA_WIDTH-1:0]     message,
  input  logic                      uart_done,
  output logic                      busy
`ifdef UART_TXQ_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  localparam int GW       = txq_w(GAP_CYCLES + 1);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  txq_state_t            state;
  txq_state_t            state_d;
  logic [GW-1:0]         gap_cnt;
  logic                  gap_done;
  logic                  uart_done_q;
  logic                  done_rise;
  logic                  pop;
  logic                  ovf_stb;
  logic [DATA_WIDTH-1:0] head;

  txq_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovf_stb (ovf_stb)
  );

  // A done level already high on SEND entry must not end the frame.
  assign done_rise = uart_done && !uart_done_q;
  assign gap_done  = (gap_cnt == GW'(GAP_LAST));
  assign send_tx   = (state == SEND);
  assign busy      = (state != IDLE);

`ifdef UART_TXQ_TIMEOUT_EN
  localparam int TW = txq_w(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == SEND && state_d == SEND) to_cnt <= to_cnt + TW'(1);
      else                                  to_cnt <= '0;
      if (state == SEND && !done_rise && to_hit) timeout <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (done_rise) state_d = GAP;
`ifdef UART_TXQ_TIMEOUT_EN
        else if (to_hit) state_d = GAP;
`endif
      end
      GAP: begin
        if (gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      message     <= '0;
      uart_done_q <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_d;
      uart_done_q <= uart_done;
      if (pop)     message  <= head;
      if (ovf_stb) overflow <= 1'b1;
      if (state == GAP && state_d == GAP) gap_cnt <= gap_cnt + GW'(1);
      else                                gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomised bench for uart_tx_queue: byte-order scoreboard, UART
// responder model and occupancy model derived from queue arithmetic.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int GAP   = 4;
  localparam int TO    = 50;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          uart_done = 1'b0;
  logic          full;
  logic          empty;
  logic [4:0]    count;
  logic          overflow;
  logic          send_tx;
  logic [DW-1:0] message;
  logic          busy;
`ifdef UART_TXQ_TIMEOUT_EN
  logic          timeout;
`endif

  uart_tx_queue #(
    .DEPTH          (DEPTH),
    .DATA_WIDTH     (DW),
    .GAP_CYCLES     (GAP)
`ifdef UART_TXQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .send_tx   (send_tx),
    .message   (message),
    .uart_done (uart_done),
    .busy      (busy)
`ifdef UART_TXQ_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes accepted but not yet sent, in order.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur = '0;
  int  acc = 0;
  int  sends = 0;
  int  cyc = 0;
  int  rise_cyc = 0;
  int  fall_cyc = 0;
  int  done_at = 0;
  int  lat = 100;
  int  chk_dur = -1;
  bit  hold = 1'b0;
  bit  prev_send = 1'b0;
  bit  pend_at_fall = 1'b0;
  bit  exp_ovf = 1'b0;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (send_tx && !prev_send) begin
      sends++;
      if (exp_q.size() == 0) begin
        chk("spurious_send", 32'd1, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        chk("msg_order", 32'(message), 32'(cur));
      end
      if (pend_at_fall) chk("gap_len", cyc - fall_cyc, GAP + 1);
      pend_at_fall = 1'b0;
      rise_cyc = cyc;
      done_at  = cyc + lat;
    end
    if (!send_tx && prev_send) begin
      fall_cyc     = cyc;
      pend_at_fall = (acc - sends) > 0;
      if (chk_dur > 0) chk("send_len", cyc - rise_cyc, chk_dur);
      chk("msg_keep", 32'(message), 32'(cur));
    end
    uart_done = send_tx && !hold && (cyc >= done_at) && !uart_done;
    prev_send = send_tx;
  endtask

  task automatic push(input logic [DW-1:0] b);
    if (acc - sends < DEPTH) begin
      exp_q.push_back(b);
      acc++;
    end else begin
      exp_ovf = 1'b1;
    end
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_fall();
    int f0 = fall_cyc;
    int n  = 0;
    while (fall_cyc == f0 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) chk("fall_timeout", 32'd1, 32'd0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    acc          = 0;
    sends        = 0;
    prev_send    = 1'b0;
    pend_at_fall = 1'b0;
    exp_ovf      = 1'b0;
    cur          = '0;
    uart_done    = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] b;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_send", 32'(send_tx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_msg", 32'(message), 32'd0);
`ifdef UART_TXQ_TIMEOUT_EN
    chk("rst_timeout", 32'(timeout), 32'd0);
`endif
    reset = 1'b0;
    repeat (20) tick();
    chk("idle_msg", 32'(message), 32'd0);
    chk("idle_send", 32'(send_tx), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // two back-to-back bytes, UART answers 100 cycles after each rise
    lat = 100;
    chk_dur = lat + 1;
    push(8'h48);
    push(8'h69);
    drain();
    chk_dur = -1;
    chk("hi_count", 32'(count), 32'd0);
    chk("hi_empty", 32'(empty), 32'd1);

    // fill past capacity while the UART is stuck
    hold = 1'b1;
    lat  = 10;
    for (int i = 0; i < 17; i++) push(8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'(acc - sends));
    chk("fill_ovf0", 32'(overflow), 32'd0);
    push(8'hAA);
    chk("ovf_set", 32'(overflow), 32'(exp_ovf));
    chk("ovf_count", 32'(count), 32'd16);
    hold = 1'b0;
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // push lands on the same edge as the pop at count 5
    hold = 1'b1;
    for (int i = 0; i < 6; i++) push(8'($urandom_range(0, 255)));
    chk("pre_count", 32'(count), 32'd5);
    hold = 1'b0;
    wait_fall();
    repeat (4) tick();
    chk("pre_pop_count", 32'(count), 32'd5);
    push(8'h99);
    chk("pop_now", 32'(send_tx), 32'd1);
    chk("same_cyc_count", 32'(count), 32'd5);
    drain();

    // random traffic with random UART latency
    for (int r = 0; r < 3; r++) begin
      lat = $urandom_range(1, 30);
      for (int i = 0; i < 8; i++) begin
        b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) push(b);
        else tick();
      end
      drain();
      chk("rnd_count", 32'(count), 32'd0);
    end

    // reset in the middle of a frame
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    chk("mid_send", 32'(send_tx), 32'd1);
    chk("mid_count", 32'(count), 32'd3);
    reset = 1'b1;
    #1;
    chk("async_send", 32'(send_tx), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_ovf", 32'(overflow), 32'd0);
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
    hold  = 1'b0;
    repeat (20) tick();
    chk("post_rst_send", 32'(send_tx), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef UART_TXQ_TIMEOUT_EN
    hold    = 1'b1;
    lat     = 10;
    chk_dur = TO;
    push(8'hC1);
    push(8'hC2);
    wait_fall();
    chk_dur = -1;
    chk("timeout_set", 32'(timeout), 32'd1);
    hold = 1'b0;
    drain();
    chk("timeout_sticky", 32'(timeout), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Transmit byte queue between the MIPS core and the UART transmitter. The core pushes bytes with a single-cycle write strobe and never stalls on an in-flight frame. The block buffers bytes in a FIFO and pops them one at a time. It runs the send/done handshake with the UART: it drives the message byte and the send request, then waits for the frame-done indication.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- DATA_WIDTH, 8, byte width presented to the UART.
- GAP_CYCLES, 4, idle clock cycles after each frame completes before the next send request.
- TIMEOUT_CYCLES, 2000000, done-wait watchdog limit. Used only with UART_TXQ_TIMEOUT_EN.

Ports:
- clock  in  1  system clock (100 MHz PLL domain).
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  push strobe from the core; one byte per cycle.
- wr_data  in  DATA_WIDTH  byte to enqueue.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set on a push while full; cleared only by reset.
- send_tx  out  1  active-high send request to the UART. The top level inverts it if the UART expects active-low.
- message  out  DATA_WIDTH  byte under transmission; stable while send_tx is high.
- uart_done  in  1  UART frame-complete indication (level or pulse).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: full=0, empty=1, count=0, overflow=0, send_tx=0, message=0, busy=0. Pointers and FSM go to IDLE. FIFO contents are don't-care.
- Push: wr_en && !full writes at the tail and increments count the next cycle. wr_en && full drops the byte and sets overflow.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. A push while full is rejected even if a pop occurs in the same cycle, because full is evaluated before the pop.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full and empty are derived from count.
- uart_done edge detection: the block registers uart_done and uses done_rise = uart_done && !uart_done_q. A done level that is already high when SEND is entered does not complete the frame.
- FSM:
  - IDLE: if !empty, pop the head into the message register and go to SEND. Pop latency is 1 cycle, so send_tx rises on the cycle after the head was popped.
  - SEND: send_tx=1 and message is held. On done_rise, send_tx=0 and go to GAP.
  - GAP: count GAP_CYCLES cycles with send_tx=0, then go to IDLE. GAP_CYCLES=0 goes to IDLE on the next cycle.
- Throughput: at most one byte per UART frame plus GAP_CYCLES+2 cycles.
- message keeps the last byte sent after SEND exits. It updates only on a pop.
- Reset mid-frame: send_tx drops immediately (asynchronous), the queue is emptied, and the current byte is lost. The UART's own reset handles the partially sent frame.
- No underflow case exists: a pop occurs only when !empty.

Optional Feature:
UART_TXQ_TIMEOUT_EN
- Defined:
  - A counter runs in SEND and is cleared on entry.
  - If TIMEOUT_CYCLES elapse without done_rise: send_tx drops, the FSM goes to GAP, the byte is discarded, and the extra output timeout (1 bit, sticky, reset 0) sets.
- Undefined:
  - No counter and no timeout port.
  - SEND waits indefinitely.

Decomposition:
- Package uart_txq_pkg: FSM state enum (IDLE, SEND, GAP), default DEPTH/GAP constants, and a clog2-based width helper constant.
- Sub-module txq_fifo: synchronous FIFO with storage, pointers, count, full/empty and an overflow strobe, parameterised by DEPTH and DATA_WIDTH.
- uart_tx_queue contains the handshake FSM, done edge detection, gap counter and optional watchdog.

Test Plan:
- Reset then idle -> empty=1, count=0, send_tx=0, busy=0; message stays 0 for 20 cycles.
- Push 0x48, 0x69 back-to-back; model UART asserts uart_done 100 cycles after each send_tx rise.
  - Required: message=0x48 with send_tx high until done.
  - Required: send_tx low for GAP_CYCLES+1 cycles.
  - Required: then message=0x69.
  - Required: count returns to 0.
- Push 17 bytes (0x00..0x10) at DEPTH=16 while the UART is held not-done.
  - Required: the first byte is popped; the 17th push is accepted; full=1.
  - Required: an 18th push (0xAA) sets overflow=1 and the byte never appears on message.
- Push and pop in the same cycle at count=5 -> count stays 5; byte order is preserved.
- Assert reset while in SEND with 3 bytes queued -> send_tx=0 and count=0 asynchronously; after release the FSM is in IDLE and no send occurs.
- With UART_TXQ_TIMEOUT_EN and TIMEOUT_CYCLES=50, uart_done is never asserted.
  - Required: send_tx falls at cycle 50 of SEND and timeout=1.
  - Required: the next queued byte is sent after the gap.
